// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad and emits one debounced key code per press
module keypad_scanner #(
    parameter int SCAN_DIV        = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t state, state_n;
    logic [1:0] row, row_n, col, col_n, low_col;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] col_m, col_s, code_n, mapped;
    logic valid_n, held_n, key_open;

    assign filas = ~(4'b0001 << row);
    assign key_open = col_s[col];
    assign low_col = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
    assign mapped = (row == 2'd3) ? ((col == 2'd0) ? 4'hE : (col == 2'd1) ? 4'h0 :
                                     (col == 2'd2) ? 4'hF : 4'hD)
                  : (col == 2'd3) ? 4'hA + 4'(row)
                  : 4'(row) * 4'd3 + 4'(col) + 4'd1;

    // two-flop synchronizer; resets to "all released" so no false detect
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {col_s, col_m} <= 8'hFF;
        else        {col_s, col_m} <= {col_m, columnas};

    // state and output registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= SCAN;
            row       <= 2'd0;
            col       <= 2'd0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            col       <= col_n;
            cnt       <= cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end

    // scan / debounce sequencing; row stays frozen from detect until release
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        cnt_n   = cnt;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
        case (state)
            SCAN:
                if (cnt == SCAN_LAST) begin
                    cnt_n = '0;
                    if (col_s == 4'hF) row_n = row + 2'd1;
                    else begin
                        col_n   = low_col;
                        state_n = DEB_PRESS;
                    end
                end else cnt_n = cnt + CW'(1);
            DEB_PRESS:
                if (key_open) begin
                    state_n = SCAN;
                    row_n   = row + 2'd1;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = HELD;
                    code_n  = mapped;
                    valid_n = 1'b1;
                    held_n  = 1'b1;
                    cnt_n   = '0;
                end else cnt_n = cnt + CW'(1);
            HELD:
                if (key_open) begin
                    state_n = DEB_REL;
                    cnt_n   = '0;
                end
            DEB_REL:
                if (!key_open) cnt_n = '0;
                else if (cnt == DEB_LAST) begin
                    state_n = SCAN;
                    row_n   = row + 2'd1;
                    cnt_n   = '0;
                    held_n  = 1'b0;
                end else cnt_n = cnt + CW'(1);
            default: state_n = SCAN;
        endcase
    end
endmodule
